// File: rtl/dram_arbiter_if.sv
// Bus bundle between the two requesters (CPU, DMA), the data-RAM ports and dram_arbiter.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface dram_arbiter_if #(
  parameter int AW = 9
);
  logic          cpu_req;
  logic          cpu_we;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [31:0]   cpu_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [31:0]   dma_addr;
  logic [31:0]   dma_wdata;
  logic          dma_lock;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [31:0]   dma_rdata;

  logic [AW-1:0] ram_rdaddress;
  logic          ram_rden;
  logic [AW-1:0] ram_wraddress;
  logic          ram_wren;
  logic [31:0]   ram_data;
  logic [31:0]   ram_q;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
    output dma_gnt, dma_rvalid, dma_rdata,
    output ram_rdaddress, ram_rden, ram_wraddress, ram_wren, ram_data,
    input  ram_q
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  ram_rdaddress, ram_rden, ram_wraddress, ram_wren, ram_data,
    output ram_q
  );
endinterface

// File: rtl/dram_arbiter.sv
// Data-RAM arbiter: CPU fixed priority, DMA starvation guard and bounded locked bursts.
// Optional macro DRAM_ARB_BYPASS_EN: concurrent write+read grants with write-to-read forwarding.
module dram_arbiter #(
  parameter int AW         = 9,
  parameter int STARVE_MAX = 8,
  parameter int BURST_MAX  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  dram_arbiter_if.slave  bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {ARB, BURST, YIELD} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          owner_q, owner_d;   // 0 = CPU, 1 = DMA
  logic          cpu_gnt, dma_gnt;
  logic          force_dma;
  logic          cpu_rd, dma_rd, cpu_wr, dma_wr;
  logic [31:0]   ret_data;

  assign force_dma = (starve_cnt_q == SW'(STARVE_MAX));

`ifdef DRAM_ARB_BYPASS_EN
  logic [AW-1:0] cpu_word, dma_word;
  logic          wr_vld_q, fwd_q, fwd_d;
  logic [AW-1:0] wr_addr_q;
  logic [31:0]   wr_data_q, fwd_data_q;
  assign cpu_word = bus.cpu_addr[AW+1:2];
  assign dma_word = bus.dma_addr[AW+1:2];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB;
      starve_cnt_q <= '0;
      burst_cnt_q  <= '0;
      rd_pend_q    <= 1'b0;
      owner_q      <= 1'b0;
`ifdef DRAM_ARB_BYPASS_EN
      wr_vld_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      fwd_q        <= 1'b0;
      fwd_data_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      rd_pend_q    <= rd_pend_d;
      owner_q      <= owner_d;
`ifdef DRAM_ARB_BYPASS_EN
      wr_vld_q     <= bus.ram_wren;
      wr_addr_q    <= bus.ram_wraddress;
      wr_data_q    <= bus.ram_data;
      fwd_q        <= fwd_d;
      fwd_data_q   <= wr_data_q;
`endif
    end
  end

  // Grant decode per state.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    case (state_q)
      ARB: begin
        dma_gnt = bus.dma_req && (!bus.cpu_req || force_dma);
        cpu_gnt = bus.cpu_req && !dma_gnt;
`ifdef DRAM_ARB_BYPASS_EN
        // A write and a read to different words can share the cycle on the split RAM ports.
        if (cpu_gnt && bus.dma_req && (bus.cpu_we != bus.dma_we) && (cpu_word != dma_word))
          dma_gnt = 1'b1;
        else if (dma_gnt && bus.cpu_req && (bus.cpu_we != bus.dma_we) && (cpu_word != dma_word))
          cpu_gnt = 1'b1;
`endif
      end
      BURST:   dma_gnt = bus.dma_req;
      YIELD:   cpu_gnt = bus.cpu_req;
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    starve_cnt_d = starve_cnt_q;
    if (!bus.dma_req || dma_gnt)
      starve_cnt_d = '0;
    else if (!force_dma)
      starve_cnt_d = starve_cnt_q + SW'(1);
    case (state_q)
      ARB: begin
        if (dma_gnt && bus.dma_lock) begin
          burst_cnt_d = BW'(1);
          state_d     = (BURST_MAX <= 1) ? YIELD : BURST;
        end
      end
      BURST: begin
        if (!bus.dma_req || !bus.dma_lock) begin
          state_d     = ARB;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_cnt_q + BW'(1);
          if (burst_cnt_d == BW'(BURST_MAX))
            state_d = YIELD;
        end
      end
      YIELD: begin
        state_d     = ARB;
        burst_cnt_d = '0;
      end
      default: state_d = ARB;
    endcase
  end

  assign cpu_rd = cpu_gnt && !bus.cpu_we;
  assign dma_rd = dma_gnt && !bus.dma_we;
  assign cpu_wr = cpu_gnt && bus.cpu_we;
  assign dma_wr = dma_gnt && bus.dma_we;

  always_comb begin
    bus.ram_wren      = 1'b0;
    bus.ram_wraddress = '0;
    bus.ram_data      = '0;
    bus.ram_rden      = 1'b0;
    bus.ram_rdaddress = '0;
    if (cpu_wr) begin
      bus.ram_wren      = 1'b1;
      bus.ram_wraddress = bus.cpu_addr[AW+1:2];
      bus.ram_data      = bus.cpu_wdata;
    end else if (dma_wr) begin
      bus.ram_wren      = 1'b1;
      bus.ram_wraddress = bus.dma_addr[AW+1:2];
      bus.ram_data      = bus.dma_wdata;
    end
    if (cpu_rd) begin
      bus.ram_rden      = 1'b1;
      bus.ram_rdaddress = bus.cpu_addr[AW+1:2];
    end else if (dma_rd) begin
      bus.ram_rden      = 1'b1;
      bus.ram_rdaddress = bus.dma_addr[AW+1:2];
    end
  end

  always_comb begin
    rd_pend_d = cpu_rd || dma_rd;
    owner_d   = owner_q;
    if (cpu_rd)
      owner_d = 1'b0;
    else if (dma_rd)
      owner_d = 1'b1;
  end

`ifdef DRAM_ARB_BYPASS_EN
  // Read hitting last cycle's write word returns the written data, not the RAM output.
  assign fwd_d    = bus.ram_rden && wr_vld_q && (bus.ram_rdaddress == wr_addr_q);
  assign ret_data = fwd_q ? fwd_data_q : bus.ram_q;
`else
  assign ret_data = bus.ram_q;
`endif

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.cpu_rvalid = rd_pend_q && !owner_q;
  assign bus.dma_rvalid = rd_pend_q && owner_q;
  assign bus.cpu_rdata  = (rd_pend_q && !owner_q) ? ret_data : 32'h0;
  assign bus.dma_rdata  = (rd_pend_q && owner_q)  ? ret_data : 32'h0;
endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a behavioural 1-cycle-latency data RAM.
module tb_dram_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] mem [0:511];

  dram_arbiter_if #(.AW(9)) bus ();

  dram_arbiter #(.AW(9), .STARVE_MAX(8), .BURST_MAX(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) begin
      mem[0]     <= 32'h0BAD_F00D;
      mem[1]     <= 32'h1234_ABCD;
      mem[4]     <= 32'hDEAD_BEEF;
      bus.ram_q  <= 32'h0;
    end else begin
      if (bus.ram_wren) mem[bus.ram_wraddress] <= bus.ram_data;
      if (bus.ram_rden) bus.ram_q <= mem[bus.ram_rdaddress];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0; bus.dma_lock = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_gnt", bus.cpu_gnt, 0);
    chk("rst_dma_gnt", bus.dma_gnt, 0);
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_dma_rvalid", bus.dma_rvalid, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_ram_en", {bus.ram_wren, bus.ram_rden}, 0);
    rst_n = 1'b1;
    tick();

    // CPU read of word 4
    bus.cpu_req = 1; bus.cpu_addr = 32'h10;
    #1;
    chk("rd_cpu_gnt", bus.cpu_gnt, 1);
    chk("rd_ram_rden", bus.ram_rden, 1);
    chk("rd_ram_rdaddr", bus.ram_rdaddress, 4);
    tick();
    idle();
    #1;
    chk("rd_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("rd_cpu_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
    chk("rd_dma_rvalid", bus.dma_rvalid, 0);
    tick();
    chk("rd_cpu_rvalid_off", bus.cpu_rvalid, 0);

    // Both requesting: 8 CPU grants then a forced DMA grant, repeated
    bus.cpu_req = 1; bus.cpu_addr = 32'h0;
    bus.dma_req = 1; bus.dma_addr = 32'h4;
    for (int c = 0; c < 18; c++) begin
      #1;
      chk($sformatf("starve_cpu_gnt_c%0d", c), bus.cpu_gnt, (c % 9 != 8));
      chk($sformatf("starve_dma_gnt_c%0d", c), bus.dma_gnt, (c % 9 == 8));
      tick();
    end
    idle();
    tick();

    // Locked DMA write burst: entry grant with CPU idle, then CPU requests throughout
    bus.dma_req = 1; bus.dma_we = 1; bus.dma_lock = 1;
    bus.dma_addr = 32'h40; bus.dma_wdata = 32'hA5A5_0000;
    #1;
    chk("burst_entry_gnt", bus.dma_gnt, 1);
    chk("burst_ram_wren", bus.ram_wren, 1);
    chk("burst_ram_wraddr", bus.ram_wraddress, 16);
    chk("burst_ram_data", bus.ram_data, 32'hA5A5_0000);
    tick();
    bus.cpu_req = 1; bus.cpu_addr = 32'h0;
    for (int b = 1; b < 16; b++) begin
      bus.dma_addr  = 32'h40 + 32'(b) * 4;
      bus.dma_wdata = 32'hA5A5_0000 + 32'(b);
      #1;
      chk($sformatf("burst_dma_gnt_b%0d", b), bus.dma_gnt, 1);
      chk($sformatf("burst_cpu_gnt_b%0d", b), bus.cpu_gnt, 0);
      tick();
    end
    bus.dma_addr = 32'h80; bus.dma_wdata = 32'hA5A5_0010;
    #1;
    chk("yield_cpu_gnt", bus.cpu_gnt, 1);
    chk("yield_dma_gnt", bus.dma_gnt, 0);
    tick();
    chk("post_yield_cpu_gnt", bus.cpu_gnt, 1);
    chk("post_yield_dma_gnt", bus.dma_gnt, 0);
    idle();
    tick();
    chk("burst_mem16", mem[16], 32'hA5A5_0000);
    chk("burst_mem31", mem[31], 32'hA5A5_000F);

    // Interleaved reads: CPU word 0 then DMA word 1
    bus.cpu_req = 1; bus.cpu_addr = 32'h0;
    #1;
    chk("il_cpu_gnt", bus.cpu_gnt, 1);
    tick();
    bus.cpu_req = 0;
    bus.dma_req = 1; bus.dma_addr = 32'h4;
    #1;
    chk("il_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("il_cpu_rdata", bus.cpu_rdata, 32'h0BAD_F00D);
    chk("il_dma_gnt", bus.dma_gnt, 1);
    tick();
    idle();
    #1;
    chk("il_dma_rvalid", bus.dma_rvalid, 1);
    chk("il_dma_rdata", bus.dma_rdata, 32'h1234_ABCD);
    chk("il_cpu_rvalid_off", bus.cpu_rvalid, 0);
    chk("il_cpu_rdata_zero", bus.cpu_rdata, 0);
    tick();

    // Reset right after a granted read discards the return
    bus.cpu_req = 1; bus.cpu_addr = 32'h10;
    tick();
    rst_n = 1'b0;
    idle();
    #1;
    chk("mid_rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("mid_rst_cpu_rdata", bus.cpu_rdata, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_rvalid", {bus.cpu_rvalid, bus.dma_rvalid}, 0);
    chk("post_rst_gnt", {bus.cpu_gnt, bus.dma_gnt}, 0);
    chk("post_rst_ram_en", {bus.ram_wren, bus.ram_rden}, 0);

`ifdef DRAM_ARB_BYPASS_EN
    // Write then read of the same word on consecutive cycles
    bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 32'h20; bus.dma_wdata = 32'h1234_5678;
    #1;
    chk("byp_dma_gnt", bus.dma_gnt, 1);
    tick();
    idle();
    bus.cpu_req = 1; bus.cpu_addr = 32'h20;
    #1;
    chk("byp_cpu_gnt", bus.cpu_gnt, 1);
    tick();
    idle();
    #1;
    chk("byp_cpu_rdata", bus.cpu_rdata, 32'h1234_5678);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
